mult_share_ctrl: RTL and testbench

- Controller that shares one 16x16 unsigned `array_mult` instance among N_REQ requesters.
- Arbitrates round-robin between requesters and registers the granted operands.
- Treats the multiplier as a MUL_LAT-cycle multicycle path and captures the 32-bit product.
- Returns the product with the requester ID over a single-entry valid/ready response port.
- Sits between compute clients and the shared multiplier datapath.

---
 rtl/mult_share_pkg.sv | 16 +
 rtl/array_mult.sv | 20 ++
 rtl/mult_share_ctrl_rr_arbiter.sv | 41 ++++
 rtl/mult_share_ctrl.sv | 111 +++++++++++
 tb/tb_mult_share_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and widths for the multiplier-sharing controller.
//   OP_W    : operand width of the shared multiplier
//   P_W     : full product width
//   state_t : controller FSM states
package mult_share_pkg;

    localparam int unsigned OP_W = 16;
    localparam int unsigned P_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/array_mult.sv
// Combinational 16x16 unsigned multiplier (shift-and-add array).
//   a : multiplicand
//   b : multiplier
//   p : full 32-bit unsigned product
module array_mult (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    always_comb begin
        p = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (b[i]) begin
                p = p + ({16'b0, a} << i);
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        : request vector
//   last_grant : index granted most recently; search starts just above it
//   grant      : one-hot winner (zero when no request)
//   grant_idx  : index of the winner
//   any_req    : at least one request is present
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_req
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        // Scan last_grant+1 .. last_grant+N_REQ modulo N_REQ; the last
        // candidate is last_grant itself, so it is served only when alone.
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = (32'(last_grant) + i) % N_REQ;
            if (!found && req[idx[ID_W-1:0]]) begin
                found                  = 1'b1;
                grant[idx[ID_W-1:0]]   = 1'b1;
                grant_idx              = idx[ID_W-1:0];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one combinational array_mult among N_REQ requesters.
// Round-robin grant, operands registered at the grant, MUL_LAT-cycle
// multicycle settle, then product returned on a valid/ready port.
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/req_ready: per-requester handshake (ready one-hot or zero)
//   req_a, req_b       : packed 16-bit operands, requester k at [16k+15:16k]
//   resp_valid/ready   : single-entry response handshake
//   resp_id, resp_p    : owner index and 32-bit product
//   busy               : controller not idle
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [OP_W*N_REQ-1:0] req_a,
    input  logic [OP_W*N_REQ-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [P_W-1:0]        resp_p,
    output logic                  busy
);

    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [CNT_W-1:0]  cnt;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic [ID_W-1:0]   op_id;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              any_req;
    logic [P_W-1:0]    prod;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_req    (any_req)
    );

    array_mult u_mult (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    // Ready is masked during reset so no requester sees an accept
    // that the registers will not honour.
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(N_REQ - 1);
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_a       <= req_a[grant_idx*OP_W +: OP_W];
                        op_b       <= req_b[grant_idx*OP_W +: OP_W];
                        op_id      <= grant_idx;
                        last_grant <= grant_idx;
                        cnt        <= CNT_W'(MUL_LAT - 1);
                        state      <= CALC;
                    end
                end
                CALC: begin
                    // resp_id is loaded here, not at the grant, so it stays
                    // unchanged between responses.
                    if (cnt == '0) begin
                        resp_p     <= prod;
                        resp_id    <= op_id;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed self-checking bench for mult_share_ctrl (MUL_LAT=4 and MUL_LAT=1).
module tb_mult_share_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT, MUL_LAT = 4
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [31:0] resp_p;
    logic        busy;

    // second DUT, MUL_LAT = 1
    logic        rst1;
    logic [3:0]  req_valid1;
    logic [3:0]  req_ready1;
    logic [63:0] req_a1;
    logic [63:0] req_b1;
    logic        resp_valid1;
    logic        resp_ready1;
    logic [1:0]  resp_id1;
    logic [31:0] resp_p1;
    logic        busy1;

    int n_checks = 0;
    int n_fail   = 0;

    mult_share_ctrl #(.N_REQ(4), .ID_W(2), .MUL_LAT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_p     (resp_p),
        .busy       (busy)
    );

    mult_share_ctrl #(.N_REQ(4), .ID_W(2), .MUL_LAT(1)) dut1 (
        .clk        (clk),
        .rst        (rst1),
        .req_valid  (req_valid1),
        .req_ready  (req_ready1),
        .req_a      (req_a1),
        .req_b      (req_b1),
        .resp_valid (resp_valid1),
        .resp_ready (resp_ready1),
        .resp_id    (resp_id1),
        .resp_p     (resp_p1),
        .busy       (busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated request from requester k; response held for 'hold' cycles.
    task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          input int hold, input logic [31:0] exp_p, input string tag);
        logic [3:0] oh;
        int cyc;
        int lat;
        oh = 4'b0001 << k;
        resp_ready = (hold == 0);
        req_a[k*16 +: 16] = a;
        req_b[k*16 +: 16] = b;
        req_valid[k] = 1'b1;
        #1;
        cyc = 0;
        while (req_ready != oh && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'(oh));
        tick();                       // handshake edge E0
        req_valid[k] = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_p"}, resp_p, exp_p);
        check({tag, "_id"}, 32'(resp_id), 32'(k));
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, "_hold_v"}, 32'(resp_valid), 32'd1);
            check({tag, "_hold_p"}, resp_p, exp_p);
            check({tag, "_hold_id"}, 32'(resp_id), 32'(k));
        end
        resp_ready = 1'b1;
        tick();
        check({tag, "_clr_v"}, 32'(resp_valid), 32'd0);
        check({tag, "_clr_busy"}, 32'(busy), 32'd0);
        check({tag, "_keep_p"}, resp_p, exp_p);
        check({tag, "_keep_id"}, 32'(resp_id), 32'(k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [5];
        int cyc;
        logic [3:0] oh;
        logic [31:0] exp1;

        rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0; resp_ready = 1'b0;
        rst1 = 1'b1; req_valid1 = 4'b0000; req_a1 = '0; req_b1 = '0; resp_ready1 = 1'b1;

        // reset state with all requesters valid
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_p", resp_p, 32'd0);
        req_valid = 4'b0000;
        rst = 1'b0;
        tick();

        // single request, latency, hold, corner values
        run_op(1, 16'd3, 16'd5, 0, 32'h0000000F, "single");
        run_op(1, 16'd3, 16'd5, 3, 32'h0000000F, "hold3");
        run_op(3, 16'hFFFF, 16'hFFFF, 0, 32'hFFFE0001, "max");
        run_op(2, 16'd1234, 16'd5678, 0, 32'h006AE9BC, "mid");
        run_op(0, 16'd0, 16'hABCD, 0, 32'h00000000, "zero");

        // fairness: 0, 2, 3 valid from reset
        order = '{0, 2, 3, 0, 2};
        for (int k = 0; k < 4; k++) begin
            req_a[k*16 +: 16] = 16'(k + 10);
            req_b[k*16 +: 16] = 16'(k + 20);
        end
        rst = 1'b1; req_valid = 4'b1101; resp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int r = 0; r < 5; r++) begin
            oh = 4'b0001 << order[r];
            cyc = 0;
            while (req_ready == 4'b0000 && cyc < 20) begin
                tick();
                cyc++;
            end
            check("rr_grant", 32'(req_ready), 32'(oh));
            tick();
            cyc = 0;
            while (!resp_valid && cyc < 20) begin
                tick();
                cyc++;
            end
            check("rr_valid", 32'(resp_valid), 32'd1);
            check("rr_id", 32'(resp_id), 32'(order[r]));
            check("rr_p", resp_p, 32'((order[r] + 10) * (order[r] + 20)));
            tick();
        end
        req_valid = 4'b0000;
        tick();

        // reset two cycles into CALC
        req_a[32 +: 16] = 16'd7; req_b[32 +: 16] = 16'd9;
        req_a[0 +: 16]  = 16'd2; req_b[0 +: 16]  = 16'd3;
        req_valid = 4'b0100;
        #1;
        check("mid_rst_grant", 32'(req_ready), 32'b0100);
        tick();                       // handshake
        req_valid = 4'b0000;
        tick();
        tick();
        rst = 1'b1; req_valid = 4'b0101;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("mid_rst_no_resp", 32'(resp_valid), 32'd0);
            if (c == 1) rst = 1'b0;
        end
        // two edges out of reset have now passed with req 0 and 2 valid;
        // restart from a clean reset to observe the first post-reset grant
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_grant", 32'(req_ready), 32'b0001);
        req_valid = 4'b0001;
        run_op(0, 16'd2, 16'd3, 0, 32'd6, "post_rst");

        // MUL_LAT=1: back-to-back from requester 0
        exp1 = '0;
        req_valid1 = 4'b0001;
        tick();
        rst1 = 1'b0;
        #1;
        for (int t = 0; t < 9; t++) begin
            if (t % 3 == 0) begin
                check("l1_ready", 32'(req_ready1), 32'b0001);
                req_a1[15:0] = 16'(t + 1);
                req_b1[15:0] = 16'(t + 100);
                exp1 = 32'((t + 1) * (t + 100));
            end else begin
                check("l1_ready_idle", 32'(req_ready1), 32'd0);
            end
            check("l1_valid", 32'(resp_valid1), 32'((t % 3) == 2));
            if (t % 3 == 2) begin
                check("l1_p", resp_p1, exp1);
                check("l1_id", 32'(resp_id1), 32'd0);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
